uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the team's UART transmitter.
- Recovers 8-bit frames from a serial line: 1 start bit (0), 8 data bits, 1 stop bit (1), idle high.
- Bit period is set at runtime by the same 24-bit divisor the transmitter uses.
- Delivers each byte on a valid/ready interface and flags framing errors and overruns.

Parameters:
- MSB_FIRST, 1, 1: the first data bit after start is rx_data[7], matching the transmitter. 0: LSB first.
- SYNC_STAGES, 2, number of flip-flops synchronising the rx line (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- divisor  in  24  bit period = divisor+1 clk cycles; sampled on the start-bit falling edge.
- rx  in  1  asynchronous serial input, idle high.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts; a transfer occurs on rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse when the stop bit samples 0.
- overrun  out  1  one-cycle pulse when a good byte is dropped because rx_valid was still high.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops reset to 1; FSM goes to IDLE; counters are 0.
- Reset mid-frame aborts the frame with no pulses; the next frame needs a fresh falling edge.
- Timing:
  - P = divisor+1 (25-bit arithmetic, no overflow).
  - H = P>>1.
  - divisor is latched into an internal register on START entry; changes mid-frame are ignored.
  - divisor < 3 is unsupported.
- States: IDLE, START, DATA, STOP, BREAK. Counter cnt counts clk cycles; bit index idx runs 0..7.
- IDLE:
  - Synchronised rx falling edge (prev=1, now=0) → START, cnt=0.
- START:
  - When cnt==H-1, sample rx_s.
  - If 0: go to DATA, cnt=0, idx=0.
  - If 1: glitch; return to IDLE with no output.
- DATA:
  - When cnt==P-1, sample rx_s into the shift register, cnt=0, idx++.
  - Sample points are mid-bit.
  - After idx 7 is sampled, go to STOP.
  - Bit order is set by MSB_FIRST.
- STOP:
  - When cnt==P-1, sample the stop bit.
  - If 1 and rx_valid==0 (or rx_ready is high this cycle): rx_data ← byte, rx_valid=1 next cycle. Go to IDLE.
  - If 1 and the byte cannot be taken: drop the new byte, keep the old rx_data/rx_valid, pulse overrun. Go to IDLE.
  - If 0: pulse frame_err, discard the byte, go to BREAK.
- BREAK:
  - Wait until rx_s==1, then go to IDLE. Falling-edge detect is rearmed only from the high level.
- Latency:
  - Stop-bit sample at the mid stop bit.
  - rx_valid rises on the clk after that sample.
  - From the line falling edge: SYNC_STAGES + H + 9·P cycles (±1).
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1, then clears the next edge.
  - rx_data is stable while rx_valid=1.
  - Simultaneous completion and acceptance in the same cycle: the new byte loads, rx_valid stays 1, no overrun.
- Back-to-back frames:
  - The receiver returns to IDLE at mid stop bit.
  - It can therefore catch a start edge arriving immediately after the stop bit.
- rx_ready while rx_valid=0 has no effect.

Test Plan:
- divisor=15 (P=16), MSB_FIRST=1, rx_ready=1; send 0xA5, line bits 0,1,0,1,0,0,1,0,1,1 → one rx_valid cycle with rx_data=0xA5, frame_err=0, overrun=0.
- divisor=15; rx low for 4 cycles, then high → no rx_valid, busy returns to 0 within H+SYNC_STAGES+1 cycles, no pulses.
- divisor=15; send 0x3C with stop bit 0, line held low 20 more cycles, then high → one frame_err pulse, no rx_valid. A subsequent 0x81 frame is received correctly.
- rx_ready=0; send 0x11 then 0x22 back-to-back → rx_data stays 0x11 with rx_valid high, one overrun pulse at the end of the second frame. Raise rx_ready → rx_valid clears.
- Assert rst for 1 cycle during data bit 4 of a frame → all outputs at reset values. The remainder of the frame produces no rx_valid; a following 0x5A frame is received as 0x5A.
- divisor=1250 and MSB_FIRST=0; send 0x01 LSB first → rx_data=0x01. Changing divisor mid-frame has no effect on that frame.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, runtime 24-bit bit-period divisor, valid/ready
// byte output with framing-error and overrun pulses.
module uart_rx #(
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] divisor,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    // Marks when the synchroniser holds real line samples rather than reset ones.
    logic [SYNC_STAGES-1:0] settle_q, settle_d;
    logic                   prev_q, prev_d;
    logic                   rx_s;
    logic                   fall;

    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [23:0] div_q, div_d;
    logic [23:0] half_q, half_d;

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       fe_q, fe_d;
    logic       ov_q, ov_d;

    logic [24:0] period;
    logic [7:0]  shift_in;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    // Edge detect only after the chain has flushed, so a line held low across
    // reset is never mistaken for a start bit.
    assign fall   = prev_q & ~rx_s;
    assign period = {1'b0, divisor} + 25'd1;

    assign shift_in = MSB_FIRST ? {shift_q[6:0], rx_s} : {rx_s, shift_q[7:1]};

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;
    assign busy      = (state_q != StIdle);

    // Synchroniser, settle tracker and edge-detect history.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], rx};
        settle_d = {settle_q[SYNC_STAGES-2:0], 1'b1};
        prev_d   = rx_s & settle_q[SYNC_STAGES-1];
    end

    // Next-state, counters, shift register and output registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        div_d   = div_q;
        half_d  = half_q;
        data_d  = data_q;
        valid_d = valid_q & ~rx_ready;
        fe_d    = 1'b0;
        ov_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = StStart;
                    div_d   = divisor;
                    half_d  = period[24:1] - 24'd1;
                end
            end
            StStart: begin
                if (cnt_q == half_q) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A high sample at mid start bit means the edge was a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            StData: begin
                if (cnt_q == div_q) begin
                    cnt_d   = '0;
                    shift_d = shift_in;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            StStop: begin
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
                        // Accepting the old byte this cycle frees the slot.
                        if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end else begin
                        fe_d    = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sync_q   <= '1;
            settle_q <= '0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            div_q    <= '0;
            half_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            settle_q <= settle_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            half_q   <= half_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            fe_q     <= fe_d;
            ov_q     <= ov_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes, monitors
// pop and compare on every valid/ready transfer.
module tb_uart_rx;

    logic        clk;
    logic        rst, rst2;
    logic [23:0] divisor, divisor2;
    logic        rx, rx2;
    logic [7:0]  rx_data, rx_data2;
    logic        rx_valid, rx_valid2;
    logic        rx_ready, rx_ready2;
    logic        frame_err, frame_err2;
    logic        overrun, overrun2;
    logic        busy, busy2;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    int valid_cnt2 = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];

    uart_rx #(.MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .divisor(divisor), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    uart_rx #(.MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_lsb (
        .clk(clk), .rst(rst2), .divisor(divisor2), .rx(rx2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
        .frame_err(frame_err2), .overrun(overrun2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor for the MSB-first instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) valid_cnt++;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) check("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
                else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Monitor for the LSB-first instance.
    always @(negedge clk) begin
        if (!rst2) begin
            if (rx_valid2) valid_cnt2++;
            if (rx_valid2 && rx_ready2) begin
                if (exp2_q.size() == 0) check("unexpected_byte2", {24'd0, rx_data2}, 32'hFFFF_FFFF);
                else check("rx_data2", {24'd0, rx_data2}, {24'd0, exp2_q.pop_front()});
            end
        end
    end

    // Drives one frame; called at posedge+1 and returns at posedge+1.
    task automatic send(input bit sel, input logic [7:0] b, input logic stop, input int p,
                        input bit msb);
        logic v;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) v = 1'b0;
            else if (i == 9) v = stop;
            else v = msb ? b[8-i] : b[i-1];
            if (sel) rx2 = v;
            else rx = v;
            repeat (p) @(posedge clk);
            #1;
        end
    endtask

    int v0, f0, o0;

    initial begin
        rx = 1'b1; rx2 = 1'b1; rst = 1'b1; rst2 = 1'b1;
        rx_ready = 1'b0; rx_ready2 = 1'b1;
        divisor = 24'd15; divisor2 = 24'd1250;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset state.
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Plain 0xA5 frame.
        rx_ready = 1'b1;
        v0 = valid_cnt; f0 = fe_cnt; o0 = ov_cnt;
        exp_q.push_back(8'hA5);
        send(1'b0, 8'hA5, 1'b1, 16, 1'b1);
        repeat (32) @(posedge clk);
        #1;
        check("a5_delivered", exp_q.size(), 32'd0);
        check("a5_valid_cycles", valid_cnt - v0, 32'd1);
        check("a5_no_frame_err", fe_cnt - f0, 32'd0);
        check("a5_no_overrun", ov_cnt - o0, 32'd0);

        // Start-bit glitch of 4 cycles.
        v0 = valid_cnt; f0 = fe_cnt; o0 = ov_cnt;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check("glitch_no_valid", valid_cnt - v0, 32'd0);
        check("glitch_no_pulses", (fe_cnt - f0) + (ov_cnt - o0), 32'd0);

        // Framing error on 0x3C, then a good 0x81.
        v0 = valid_cnt; f0 = fe_cnt;
        send(1'b0, 8'h3C, 1'b0, 16, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check("fe_pulse_count", fe_cnt - f0, 32'd1);
        check("fe_no_valid", valid_cnt - v0, 32'd0);
        exp_q.push_back(8'h81);
        send(1'b0, 8'h81, 1'b1, 16, 1'b1);
        repeat (32) @(posedge clk);
        #1;
        check("after_fe_delivered", exp_q.size(), 32'd0);

        // Overrun: two back-to-back frames with the consumer stalled.
        rx_ready = 1'b0;
        o0 = ov_cnt;
        exp_q.push_back(8'h11);
        send(1'b0, 8'h11, 1'b1, 16, 1'b1);
        send(1'b0, 8'h22, 1'b1, 16, 1'b1);
        repeat (32) @(posedge clk);
        #1;
        check("ovr_pulse_count", ov_cnt - o0, 32'd1);
        check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        check("ovr_data_held", {24'd0, rx_data}, 32'h11);
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ovr_valid_cleared", {31'd0, rx_valid}, 32'd0);
        check("ovr_byte_popped", exp_q.size(), 32'd0);

        // Reset during data bit 4 of an all-zero frame, then 0x5A.
        v0 = valid_cnt;
        rx = 1'b0;
        repeat (84) @(posedge clk);
        #1;
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_pulses", {30'd0, frame_err, overrun}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (59) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        check("midrst_no_valid", valid_cnt - v0, 32'd0);
        exp_q.push_back(8'h5A);
        send(1'b0, 8'h5A, 1'b1, 16, 1'b1);
        repeat (32) @(posedge clk);
        #1;
        check("after_rst_delivered", exp_q.size(), 32'd0);
        check("after_rst_valid_cycles", valid_cnt - v0, 32'd1);

        // LSB-first with a long period; divisor change mid-frame is ignored.
        v0 = valid_cnt2;
        exp2_q.push_back(8'h01);
        fork
            send(1'b1, 8'h01, 1'b1, 1251, 1'b0);
            begin
                repeat (3 * 1251) @(posedge clk);
                #2;
                divisor2 = 24'd15;
            end
        join
        repeat (2000) @(posedge clk);
        #1;
        check("lsb_delivered", exp2_q.size(), 32'd0);
        check("lsb_valid_cycles", valid_cnt2 - v0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
